// File: rtl/moore_seq_detector_if.sv
// Serial bit stream in, Moore match/debug/counter observation out.
// master drives the stream and clear; slave is the detector.
interface moore_seq_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) ();
    localparam int ST_W = $clog2(PAT_W + 1);

    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [ST_W-1:0]  state_o;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output clear, in_valid, in_bit,
        input  match, state_o, match_count, count_sat
    );

    modport slave (
        input  clear, in_valid, in_bit,
        output match, state_o, match_count, count_sat
    );
endinterface

// File: rtl/moore_seq_detector.sv
// Moore detector for a PAT_W-bit pattern with saturating match counter; match rises one cycle
// after the edge that samples the final pattern bit. No backpressure: in_valid only qualifies in_bit.
module moore_seq_detector #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int              OVERLAP = 1,
    parameter int              CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset,
    moore_seq_detector_if.slave bus
);
    localparam int               ST_W    = $clog2(PAT_W + 1);
    localparam logic [ST_W-1:0]  S0      = '0;
    localparam logic [ST_W-1:0]  S_MATCH = ST_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pattern bit idx in arrival order (idx 0 is the first bit received).
    function automatic logic pat_bit(input int idx);
        logic [PAT_W-1:0] t;
        t = PATTERN >> (PAT_W - 1 - idx);
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (prefix_k followed by b).
    function automatic int next_of(input int k_in, input int b);
        int   k;
        int   len;
        int   best;
        int   j;
        logic ok;
        logic sb;
        k    = (k_in == PAT_W && OVERLAP == 0) ? 0 : k_in;
        len  = k + 1;
        best = 0;
        for (int l = 1; l <= PAT_W; l++) begin
            if (l <= len) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    j  = len - l + i;
                    sb = (j == k) ? (b != 0) : pat_bit(j);
                    if (sb != pat_bit(i)) ok = 1'b0;
                end
                if (ok) best = l;
            end
        end
        return best;
    endfunction

    logic [ST_W-1:0] nxt_tab [0:PAT_W][0:1];

    for (genvar k = 0; k <= PAT_W; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            assign nxt_tab[k][b] = ST_W'(next_of(k, b));
        end
    end

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic             cnt_inc;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        if (state > S_MATCH) begin
            state_nxt = S0;
        end else if (bus.in_valid) begin
            state_nxt = nxt_tab[state][bus.in_bit];
            cnt_inc   = (state_nxt == S_MATCH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (bus.clear) begin
            state       <= S0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cnt_inc && match_count != CNT_MAX) begin
                match_count <= match_count + CNT_W'(1);
                if (match_count + CNT_W'(1) == CNT_MAX) count_sat <= 1'b1;
            end
        end
    end

    assign bus.match       = (state == S_MATCH);
    assign bus.state_o     = state;
    assign bus.match_count = match_count;
    assign bus.count_sat   = count_sat;
endmodule

// File: tb/tb_moore_seq_detector.sv
// Four detector configurations share one stimulus stream; a history-based model feeds a
// scoreboard queue that a monitor drains one entry per clock.
module tb_moore_seq_detector;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic reset;
    logic t_clear, t_valid, t_bit;
    logic mon_en;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // 0: 1011 overlap, 1: 1011 non-overlap, 2: 11 overlap CNT_W=2, 3: 1101 overlap CNT_W=3
    function automatic int pw(input int d);
        return (d == 2) ? 2 : 4;
    endfunction
    function automatic int pat(input int d);
        case (d)
            2:       return 3;
            3:       return 13;
            default: return 11;
        endcase
    endfunction
    function automatic int ov(input int d);
        return (d == 1) ? 0 : 1;
    endfunction
    function automatic int cw(input int d);
        case (d)
            2:       return 2;
            3:       return 3;
            default: return 8;
        endcase
    endfunction

    moore_seq_detector_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    moore_seq_detector_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    moore_seq_detector_if #(.PAT_W(2), .CNT_W(2)) if_c ();
    moore_seq_detector_if #(.PAT_W(4), .CNT_W(3)) if_d ();

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8))
        u_b (.clk(clk), .reset(reset), .bus(if_b));
    moore_seq_detector #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2))
        u_c (.clk(clk), .reset(reset), .bus(if_c));
    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(3))
        u_d (.clk(clk), .reset(reset), .bus(if_d));

    assign if_a.clear = t_clear;  assign if_a.in_valid = t_valid;  assign if_a.in_bit = t_bit;
    assign if_b.clear = t_clear;  assign if_b.in_valid = t_valid;  assign if_b.in_bit = t_bit;
    assign if_c.clear = t_clear;  assign if_c.in_valid = t_valid;  assign if_c.in_bit = t_bit;
    assign if_d.clear = t_clear;  assign if_d.in_valid = t_valid;  assign if_d.in_bit = t_bit;

    int   act_st  [ND];
    int   act_cnt [ND];
    logic act_m   [ND];
    logic act_sat [ND];

    assign act_st[0] = 32'(if_a.state_o);  assign act_cnt[0] = 32'(if_a.match_count);
    assign act_st[1] = 32'(if_b.state_o);  assign act_cnt[1] = 32'(if_b.match_count);
    assign act_st[2] = 32'(if_c.state_o);  assign act_cnt[2] = 32'(if_c.match_count);
    assign act_st[3] = 32'(if_d.state_o);  assign act_cnt[3] = 32'(if_d.match_count);
    assign act_m[0] = if_a.match;  assign act_sat[0] = if_a.count_sat;
    assign act_m[1] = if_b.match;  assign act_sat[1] = if_b.count_sat;
    assign act_m[2] = if_c.match;  assign act_sat[2] = if_c.count_sat;
    assign act_m[3] = if_d.match;  assign act_sat[3] = if_d.count_sat;

    typedef struct packed {
        logic [ND-1:0][31:0] st;
        logic [ND-1:0][31:0] cnt;
        logic [ND-1:0]       m;
        logic [ND-1:0]       sat;
    } exp_t;

    exp_t sbq[$];
    exp_t me;

    // Reference model: recent valid bits (newest in bit 0) and how many are meaningful.
    int   m_hist [ND];
    int   m_len  [ND];
    int   m_st   [ND];
    int   m_cnt  [ND];
    logic m_sat  [ND];

    task automatic chk(input string name, input int d, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d expected=%0d at t=%0t", name, d, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_hist[d] = 0; m_len[d] = 0; m_st[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0;
        end
    endtask

    // Longest pattern prefix equal to the most recent received bits.
    function automatic int lps(input int d);
        int mask;
        for (int l = m_len[d]; l >= 1; l--) begin
            mask = (1 << l) - 1;
            if ((m_hist[d] & mask) == ((pat(d) >> (pw(d) - l)) & mask)) return l;
        end
        return 0;
    endfunction

    task automatic step(input logic v, input logic b, input logic c);
        exp_t e;
        int   cmax;
        @(negedge clk);
        t_valid = v; t_bit = b; t_clear = c;
        for (int d = 0; d < ND; d++) begin
            if (c) begin
                m_hist[d] = 0; m_len[d] = 0; m_st[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0;
            end else if (v) begin
                m_hist[d] = ((m_hist[d] << 1) | (b ? 1 : 0)) & ((1 << pw(d)) - 1);
                if (m_len[d] < pw(d)) m_len[d]++;
                m_st[d] = lps(d);
                if (m_st[d] == pw(d)) begin
                    cmax = (1 << cw(d)) - 1;
                    if (m_cnt[d] < cmax) begin
                        m_cnt[d]++;
                        if (m_cnt[d] == cmax) m_sat[d] = 1'b1;
                    end
                    if (ov(d) == 0) begin
                        m_hist[d] = 0; m_len[d] = 0;
                    end
                end
            end
            e.st[d]  = m_st[d];
            e.cnt[d] = m_cnt[d];
            e.m[d]   = (m_st[d] == pw(d));
            e.sat[d] = m_sat[d];
        end
        sbq.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk({tag, "_state"}, d, act_st[d], 0);
            chk({tag, "_match"}, d, int'(act_m[d]), 0);
            chk({tag, "_count"}, d, act_cnt[d], 0);
            chk({tag, "_sat"}, d, int'(act_sat[d]), 0);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send(input int n, input int bits);
        for (int i = n - 1; i >= 0; i--) step(1'b1, 1'(bits >> i), 1'b0);
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            #2;
            if (sbq.size() > 0) begin
                me = sbq.pop_front();
                for (int d = 0; d < ND; d++) begin
                    chk("state_o", d, act_st[d], int'(me.st[d]));
                    chk("match", d, int'(act_m[d]), int'(me.m[d]));
                    chk("match_count", d, act_cnt[d], int'(me.cnt[d]));
                    chk("count_sat", d, int'(act_sat[d]), int'(me.sat[d]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; t_clear = 1'b0; t_valid = 1'b0; t_bit = 1'b0; mon_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Overlap vs non-overlap on 1,0,1,1,0,1,1
        send(7, 7'b1011011);
        step(1'b0, 1'b0, 1'b1);
        // Valid gaps with in_bit toggling
        send(2, 2'b10);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        send(2, 2'b11);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        // Ten consecutive ones: saturation of the narrow counters
        send(10, 10'h3ff);
        step(1'b0, 1'b0, 1'b1);
        // Async reset mid-pattern, then a clean match
        send(3, 3'b101);
        reset_pulse();
        send(4, 4'b1011);
        // Clear collides with the completing bit
        step(1'b0, 1'b0, 1'b1);
        send(3, 3'b101);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        // Failure-function walk for 1101
        send(5, 5'b11101);
        step(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) reset_pulse();
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
        end
        step(1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drain", 0, sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised Moore sequence detector. It watches a serial bit stream with a valid qualifier and asserts a state-decoded match flag when a programmable PAT_W-bit pattern has been received.
- Supports overlapping and non-overlapping detection modes.
- Includes a saturating match counter with a sticky saturation flag.
- Sits between a serial front end (deserialiser or line sampler) and control logic that needs a framing or sync-word indication.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, PAT_W-bit pattern; PATTERN[PAT_W-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping detection.
- CNT_W, 8, width of the match counter; legal range 1..32.
- ST_W, $clog2(PAT_W+1), state register width; derived, must not be overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of state, counter and saturation flag.
- in_valid  input  1  qualifies in_bit for the current cycle.
- in_bit  input  1  serial data bit.
- match  output  1  Moore output; high while the FSM is in the match state.
- state_o  output  ST_W  current state index, for debug and observation.
- match_count  output  CNT_W  number of matches since reset or clear; saturating.
- count_sat  output  1  sticky flag; set when match_count reaches all-ones.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - state = S0, match = 0, state_o = 0, match_count = 0, count_sat = 0.
  - Reset takes effect immediately, including mid-pattern. A partial match is discarded.
- States S0..S_PAT_W:
  - S_k means the k most recent valid bits equal the first k pattern bits (longest such prefix).
  - S_PAT_W is the match state.
- Moore output:
  - match = (state == S_PAT_W); it is a pure decode of the state register, with no combinational path from in_bit or in_valid.
  - state_o = state.
- Latency: match rises in the cycle after the rising edge that samples the final pattern bit with in_valid=1. It stays high for exactly one cycle per match unless the next valid bit keeps the FSM in S_PAT_W. That can only happen in overlap mode, for an all-equal-bit pattern.
- Transitions, evaluated only when in_valid=1:
  - From S_k, k < PAT_W, on bit b: next = length of the longest pattern prefix that is a suffix of (prefix_k followed by b). This is the KMP failure function, computed at elaboration.
  - From S_PAT_W with OVERLAP=1: as above, using prefix_PAT_W followed by b.
  - From S_PAT_W with OVERLAP=0: next = transition from S0 on b.
- in_valid=0: state holds and in_bit is ignored. Consequently match holds if already high.
- Counter:
  - match_count increments by 1 on each edge where next state = S_PAT_W and in_valid=1. Re-entry from S_PAT_W counts again.
  - At all-ones the counter holds; count_sat is set on the edge where the count becomes all-ones.
  - count_sat stays 1 until reset or clear.
- clear=1:
  - On the next edge: state = S0, match_count = 0, count_sat = 0.
  - clear has priority over a simultaneous valid bit; that bit is discarded and not counted.
- Illegal state encodings (> PAT_W): next state = S0, match = 0, no count.
- Everything except the asynchronous reset is synchronous to clk.

Test Plan:
- Overlap, PATTERN=1011, OVERLAP=1: valid bits 1,0,1,1,0,1,1 on consecutive cycles -> match high in the cycle after the 4th bit and after the 7th bit, each for one cycle; match_count = 2; state_o after the 7th bit = 4.
- Non-overlap, same stream, OVERLAP=0 -> match high only after the 4th bit; match_count = 1; state_o after the 7th bit = 1.
- Valid gaps: send 1,0, then in_valid=0 for 3 cycles with in_bit toggling, then 1,1 -> state_o holds at 2 during the gap; match after the final 1; match_count = 1.
- Saturation, CNT_W=2, PATTERN=11, OVERLAP=1: ten consecutive valid 1s -> match_count sequence 0,1,2,3,3,...; count_sat rises with the edge where the count reaches 3; match stays high from the 2nd bit on.
- Reset and clear mid-pattern:
  - Send 1,0,1, then pulse reset asynchronously between edges -> state_o = 0 and match = 0 immediately. Then 1,0,1,1 -> one match.
  - Assert clear together with a valid bit that would complete a match -> no match, match_count = 0, state = S0.
- Failure function, PATTERN=4'b1101, OVERLAP=1: stream 1,1,1,0,1 -> state_o sequence 1,2,2,3,4; match after the 5th bit.
